// File: rtl/bean_field.sv
// rtl/bean_field.sv - multi-slot bean obstacle field: spawn, per-frame move, retire count, registered pixel hit test
module bean_field #(
  parameter int N_BEANS  = 4,
  parameter int SPAWN_X  = 600,
  parameter int GROUND_Y = 380,
  parameter int BEAN_W   = 30,
  parameter int BEAN_H   = 40,
  parameter int MIN_GAP  = 160
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic [3:0]         speed,
  input  logic               spawn_req,
  output logic               bean,
  output logic [2:0]         bean_id,
  output logic [N_BEANS-1:0] active_mask,
  output logic               spawn_ack,
  output logic [7:0]         passed_cnt
);

  logic [N_BEANS-1:0] act;
  logic [9:0]         px [N_BEANS];
  logic               pend;

  logic               free_found;
  logic [N_BEANS-1:0] spawn_sel;
  logic               gap_ok;
  logic               commit;
  logic [N_BEANS-1:0] retire;
  logic [3:0]         ret_cnt;
  logic [8:0]         cnt_sum;
  logic               hit_any;
  logic [2:0]         hit_idx;
  logic [10:0]        x11;
  logic [10:0]        y11;
  logic [10:0]        lo11;
  logic [10:0]        hi11;
  logic               y_in;

  assign active_mask = act;
  assign x11  = {1'b0, x};
  assign y11  = {1'b0, y};
  assign y_in = (y11 >= 11'(GROUND_Y - BEAN_H)) && (y11 <= 11'(GROUND_Y));

  always_comb begin
    free_found = 1'b0;
    spawn_sel  = '0;
    gap_ok     = 1'b1;
    retire     = '0;
    ret_cnt    = '0;
    hit_any    = 1'b0;
    hit_idx    = '0;
    lo11       = '0;
    hi11       = '0;
    for (int i = 0; i < N_BEANS; i++) begin
      if (!act[i] && !free_found) begin
        free_found   = 1'b1;
        spawn_sel[i] = 1'b1;
      end
      if (act[i] && (int'(px[i]) > SPAWN_X - MIN_GAP))
        gap_ok = 1'b0;
      retire[i] = frame_tick && act[i] && (px[i] < {6'b0, speed});
      ret_cnt   = ret_cnt + {3'b0, retire[i]};
      lo11      = {1'b0, px[i]};
      hi11      = lo11 + 11'(BEAN_W);
      // first match wins, so the reported id is the lowest-index bean
      if (!hit_any && act[i] && y_in && (x11 >= lo11) && (x11 <= hi11)) begin
        hit_any = 1'b1;
        hit_idx = 3'(i);
      end
    end
    commit = frame_tick && pend && free_found && gap_ok;
    if (!commit)
      spawn_sel = '0;
    cnt_sum = {1'b0, passed_cnt} + {5'b0, ret_cnt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act        <= '0;
      pend       <= 1'b0;
      bean       <= 1'b0;
      bean_id    <= '0;
      spawn_ack  <= 1'b0;
      passed_cnt <= '0;
      for (int i = 0; i < N_BEANS; i++)
        px[i] <= '0;
    end else begin
      bean      <= hit_any;
      bean_id   <= hit_idx;
      spawn_ack <= commit;
      pend      <= spawn_req | (pend & ~commit);
      if (frame_tick) begin
        // a freshly spawned slot was inactive pre-tick, so it never also moves or retires
        for (int i = 0; i < N_BEANS; i++) begin
          if (spawn_sel[i]) begin
            act[i] <= 1'b1;
            px[i]  <= 10'(SPAWN_X);
          end else if (retire[i]) begin
            act[i] <= 1'b0;
          end else if (act[i]) begin
            px[i] <= px[i] - {6'b0, speed};
          end
        end
        passed_cnt <= cnt_sum[8] ? 8'hff : cnt_sum[7:0];
      end
    end
  end

endmodule

// File: tb/tb_bean_field.sv
// tb/tb_bean_field.sv - self-checking bench for bean_field: vector table, reference model, randomized run
module tb_bean_field;
  localparam int NB = 4, SX = 600, GY = 380, BW = 30, BH = 40, MG = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1, frame_tick = 1'b0, spawn_req = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic [3:0] speed = '0;
  logic       bean, spawn_ack;
  logic [2:0] bean_id;
  logic [3:0] active_mask;
  logic [7:0] passed_cnt;

  logic       rst2 = 1'b1, tick2 = 1'b0, req2 = 1'b0;
  logic [3:0] speed2 = '0;
  logic [9:0] x2 = '0, y2 = '0;
  logic       bean2, ack2;
  logic [2:0] id2;
  logic [3:0] mask2;
  logic [7:0] cnt2;

  int nchk = 0, nerr = 0;
  bit m_act[NB];
  int m_px[NB];
  bit m_pend;
  int m_cnt;

  always #5 clk = ~clk;

  bean_field dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .x(x), .y(y), .speed(speed),
    .spawn_req(spawn_req), .bean(bean), .bean_id(bean_id), .active_mask(active_mask),
    .spawn_ack(spawn_ack), .passed_cnt(passed_cnt)
  );

  // zero gap lets two beans sit close enough to retire on the same tick
  bean_field #(.MIN_GAP(0)) dut2 (
    .clk(clk), .rst(rst2), .frame_tick(tick2), .x(x2), .y(y2), .speed(speed2),
    .spawn_req(req2), .bean(bean2), .bean_id(id2), .active_mask(mask2),
    .spawn_ack(ack2), .passed_cnt(cnt2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit t, input int sp, input bit rq, input int xx, input int yy);
    int eb, ei, free, ret, em;
    bit gap_ok, commit;
    rst = r; frame_tick = t; speed = 4'(sp); spawn_req = rq; x = 10'(xx); y = 10'(yy);
    eb = 0; ei = 0;
    for (int i = 0; i < NB; i++)
      if (eb == 0 && m_act[i] && xx >= m_px[i] && xx <= m_px[i] + BW && yy >= GY - BH && yy <= GY) begin
        eb = 1; ei = i;
      end
    commit = 1'b0;
    if (r) begin
      eb = 0; ei = 0; m_pend = 1'b0; m_cnt = 0;
      for (int i = 0; i < NB; i++) begin m_act[i] = 1'b0; m_px[i] = 0; end
    end else begin
      free = -1; gap_ok = 1'b1; ret = 0;
      for (int i = NB - 1; i >= 0; i--) begin
        if (!m_act[i]) free = i;
        if (m_act[i] && m_px[i] > SX - MG) gap_ok = 1'b0;
      end
      commit = t && m_pend && free >= 0 && gap_ok;
      if (t) begin
        for (int i = 0; i < NB; i++)
          if (m_act[i]) begin
            if (m_px[i] < sp) begin m_act[i] = 1'b0; ret++; end
            else m_px[i] = m_px[i] - sp;
          end
        m_cnt = (m_cnt + ret > 255) ? 255 : m_cnt + ret;
        if (commit) begin m_act[free] = 1'b1; m_px[free] = SX; end
      end
      m_pend = rq || (m_pend && !commit);
    end
    em = 0;
    for (int i = 0; i < NB; i++) if (m_act[i]) em |= (1 << i);
    @(posedge clk); #1;
    chk("bean", bean, eb);
    chk("bean_id", bean_id, ei);
    chk("active_mask", active_mask, em);
    chk("spawn_ack", spawn_ack, int'(commit));
    chk("passed_cnt", passed_cnt, m_cnt);
  endtask

  task automatic move(input int n, input int sp);
    for (int i = 0; i < n; i++) step(0, 1, sp, 0, 0, 0);
  endtask

  task automatic step2(input bit r, input bit t, input int sp, input bit rq);
    rst2 = r; tick2 = t; speed2 = 4'(sp); req2 = rq;
    @(posedge clk); #1;
  endtask

  task automatic pair2(input bit check);
    step2(0, 0, 0, 1);
    step2(0, 1, 0, 0);
    if (check) chk("dut2_ack_a", ack2, 1);
    step2(0, 0, 0, 1);
    step2(0, 1, 1, 0);
    for (int i = 0; i < 59; i++) step2(0, 1, 10, 0);
    if (check) chk("dut2_mask_pair", mask2, 3);
    step2(0, 1, 11, 0);
    if (check) chk("dut2_mask_retired", mask2, 0);
  endtask

  typedef struct {
    bit r; bit t; int sp; bit rq; int xx; int yy;
    int e_mask; int e_ack; int e_cnt; int e_bean; int e_id;
  } vec_t;
  vec_t tbl[13];

  initial begin
    bit found;
    tbl[0]  = '{1, 0, 0, 0, 0,   0,   0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 1, 0,   0,   0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 5, 0, 0,   0,   1, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 5, 0, 615, 360, 1, 0, 0, 1, 0};
    tbl[4]  = '{0, 0, 5, 0, 631, 360, 1, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 5, 0, 630, 340, 1, 0, 0, 1, 0};
    tbl[6]  = '{0, 0, 5, 0, 615, 339, 1, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 5, 0, 600, 380, 1, 0, 0, 1, 0};
    tbl[8]  = '{0, 0, 5, 0, 599, 380, 1, 0, 0, 0, 0};
    tbl[9]  = '{0, 1, 5, 0, 600, 380, 1, 0, 0, 1, 0};
    tbl[10] = '{0, 0, 5, 0, 626, 380, 1, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 5, 0, 595, 380, 1, 0, 0, 1, 0};
    tbl[12] = '{0, 0, 5, 0, 594, 380, 1, 0, 0, 0, 0};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].r, tbl[i].t, tbl[i].sp, tbl[i].rq, tbl[i].xx, tbl[i].yy);
      chk("tbl_mask", active_mask, tbl[i].e_mask);
      chk("tbl_ack", spawn_ack, tbl[i].e_ack);
      chk("tbl_cnt", passed_cnt, tbl[i].e_cnt);
      chk("tbl_bean", bean, tbl[i].e_bean);
      chk("tbl_id", bean_id, tbl[i].e_id);
    end

    // gap too small holds the request until slot0 reaches 440
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    move(10, 10);
    step(0, 1, 0, 1, 0, 0);
    chk("gap_no_ack", spawn_ack, 0);
    move(4, 15);
    step(0, 1, 0, 0, 0, 0);
    chk("gap_ack", spawn_ack, 1);
    chk("gap_mask", active_mask, 3);
    step(0, 0, 0, 0, 600, 360);
    chk("gap_hit_id", bean_id, 1);

    // full field, then a retiring slot is not reusable on its own tick
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      if (k < 3) move(16, 10);
    end
    chk("full_mask", active_mask, 15);
    step(0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("full_no_ack", spawn_ack, 0);
    move(8, 15);
    step(0, 1, 1, 0, 0, 0);
    chk("retire_no_ack", spawn_ack, 0);
    chk("retire_mask", active_mask, 14);
    chk("retire_cnt", passed_cnt, 1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 1, 15, 0, 0, 0);
      if (spawn_ack) found = 1'b1;
    end
    chk("respawn_seen", int'(found), 1);

    // randomized run against the model
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15),
           $urandom_range(0, 7) == 0, $urandom_range(0, 700), $urandom_range(330, 390));
    step(1, 1, 15, 1, 600, 360);
    chk("rst_tick_mask", active_mask, 0);
    chk("rst_tick_cnt", passed_cnt, 0);

    // simultaneous retirement and saturation on the zero-gap instance
    step2(1, 0, 0, 0);
    chk("dut2_reset_mask", mask2, 0);
    pair2(1'b1);
    chk("dut2_cnt_2", cnt2, 2);
    for (int i = 0; i < 126; i++) pair2(1'b0);
    chk("dut2_cnt_254", cnt2, 254);
    pair2(1'b0);
    chk("dut2_cnt_sat", cnt2, 255);
    pair2(1'b0);
    chk("dut2_cnt_hold", cnt2, 255);
    step2(0, 0, 0, 1);
    step2(1, 1, 15, 1);
    chk("dut2_rst_cnt", cnt2, 0);
    chk("dut2_rst_mask", mask2, 0);
    chk("dut2_rst_ack", ack2, 0);
    chk("dut2_rst_bean", bean2, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
